// File: rtl/wr_txn_timeout_tracker.sv
`timescale 1ns/1ps
// wr_txn_timeout_tracker
// Passive AXI write-transaction monitor. Tracks up to MaxWrTxns outstanding
// writes from AW handshake through W data to B response, times each phase
// against a programmable budget, latches the first timeout (phase + ID),
// flags unexpected W/B traffic and emits per-transaction latencies on B.
//
// Ports
//   clk_i, rst_ni, clr_i                  clock, async active-low reset, sync flush
//   aw_*_i / w_*_i / b_*_i                observed AXI write channels
//   budget_aw_i/budget_w_i/budget_b_i     per-phase tick budgets
//   full_o/empty_o/outstanding_o          slot table occupancy (registered)
//   timeout_o/timeout_phase_o/timeout_id_o  sticky first timeout
//   overflow_o                            sticky: AW accepted while full
//   unexpected_w_o/unexpected_b_o         one-cycle error pulses
//   lat_valid_o/lat_id_o/lat_*_o          latency record of the freed slot
//
// Slot states
//   state  | meaning
//   FREE   | slot unused
//   W_WAIT | AW accepted, no W beat seen yet
//   W_DATA | W burst in progress
//   B_WAIT | WLAST seen, waiting for matching B
module wr_txn_timeout_tracker #(
  parameter int MaxWrTxns    = 8,
  parameter int IdWidth      = 4,
  parameter int LenWidth     = 8,
  parameter int CntWidth     = 10,
  parameter int PrescalerDiv = 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               clr_i,
  input  logic                               aw_valid_i,
  input  logic                               aw_ready_i,
  input  logic [IdWidth-1:0]                 aw_id_i,
  input  logic [LenWidth-1:0]                aw_len_i,
  input  logic                               w_valid_i,
  input  logic                               w_ready_i,
  input  logic                               w_last_i,
  input  logic                               b_valid_i,
  input  logic                               b_ready_i,
  input  logic [IdWidth-1:0]                 b_id_i,
  input  logic [CntWidth-1:0]                budget_aw_i,
  input  logic [CntWidth-1:0]                budget_w_i,
  input  logic [CntWidth-1:0]                budget_b_i,
  output logic                               full_o,
  output logic                               empty_o,
  output logic [$clog2(MaxWrTxns+1)-1:0]     outstanding_o,
  output logic                               timeout_o,
  output logic [1:0]                         timeout_phase_o,
  output logic [IdWidth-1:0]                 timeout_id_o,
  output logic                               overflow_o,
  output logic                               unexpected_w_o,
  output logic                               unexpected_b_o,
  output logic                               lat_valid_o,
  output logic [IdWidth-1:0]                 lat_id_o,
  output logic [CntWidth-1:0]                lat_aw_o,
  output logic [CntWidth-1:0]                lat_w_o,
  output logic [CntWidth-1:0]                lat_b_o
);

  localparam int SW  = $clog2(MaxWrTxns);
  localparam int OW  = $clog2(MaxWrTxns + 1);
  localparam int PSH = $clog2(PrescalerDiv);
  localparam int PW  = (PrescalerDiv > 1) ? PSH : 1;

  localparam logic [1:0] S_FREE  = 2'd0;
  localparam logic [1:0] S_WWAIT = 2'd1;
  localparam logic [1:0] S_WDATA = 2'd2;
  localparam logic [1:0] S_BWAIT = 2'd3;

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v, input logic t);
    return (t && (v != '1)) ? v + 1'b1 : v;
  endfunction

  // W budget scales with burst length; one extra bit so the sum never wraps.
  function automatic logic [CntWidth:0] w_budget(input logic [LenWidth-1:0] len,
                                                 input logic [CntWidth-1:0] base);
    logic [LenWidth:0] beats;
    beats = {1'b0, len} + 1'b1;
    return {1'b0, base} + (CntWidth+1)'(beats >> PSH);
  endfunction

  function automatic logic [SW-1:0] ptr_inc(input logic [SW-1:0] p);
    return (p == SW'(MaxWrTxns - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [1:0]          r_state  [MaxWrTxns];
  logic [1:0]          w_state_n[MaxWrTxns];
  logic [IdWidth-1:0]  r_id     [MaxWrTxns];
  logic [IdWidth-1:0]  w_id_n   [MaxWrTxns];
  logic [LenWidth-1:0] r_len    [MaxWrTxns];
  logic [LenWidth-1:0] w_len_n  [MaxWrTxns];
  logic [CntWidth-1:0] r_cnt    [MaxWrTxns];
  logic [CntWidth-1:0] w_cnt_n  [MaxWrTxns];
  logic [CntWidth-1:0] r_lat_aw [MaxWrTxns];
  logic [CntWidth-1:0] w_lat_aw_n[MaxWrTxns];
  logic [CntWidth-1:0] r_lat_w  [MaxWrTxns];
  logic [CntWidth-1:0] w_lat_w_n[MaxWrTxns];
  logic [SW-1:0]       r_fifo   [MaxWrTxns];
  logic [SW-1:0]       r_rd_ptr, r_wr_ptr;
  logic [OW-1:0]       r_fifo_cnt;
  logic [CntWidth-1:0] r_aw_cnt, w_aw_cnt_n;
  logic [PW-1:0]       r_presc;

  logic                r_full, r_empty, r_timeout, r_overflow;
  logic                r_unexp_w, r_unexp_b, r_lat_valid;
  logic [OW-1:0]       r_outst, w_outst_n;
  logic [1:0]          r_to_phase, w_to_phase;
  logic [IdWidth-1:0]  r_to_id, w_to_id, r_lat_id;
  logic [CntWidth-1:0] r_lat_aw_o, r_lat_w_o, r_lat_b_o, w_b_best;

  logic w_tick, w_aw_hs, w_w_hs, w_b_hs, w_fifo_empty;
  logic w_free_found, w_b_found, w_alloc, w_bypass, w_push, w_pop;
  logic w_unexp_w, w_unexp_b, w_b_free, w_to_hit;
  logic [SW-1:0] w_free_idx, w_b_idx, w_head;

  assign w_tick       = (r_presc == '0);
  assign w_aw_hs      = aw_valid_i && aw_ready_i;
  assign w_w_hs       = w_valid_i && w_ready_i;
  assign w_b_hs       = b_valid_i && b_ready_i;
  assign w_fifo_empty = (r_fifo_cnt == '0);
  assign w_head       = r_fifo[r_rd_ptr];

  // Next-state logic for the slot table, W-order FIFO and monitors.
  always_comb begin
    w_state_n  = r_state;
    w_id_n     = r_id;
    w_len_n    = r_len;
    w_cnt_n    = r_cnt;
    w_lat_aw_n = r_lat_aw;
    w_lat_w_n  = r_lat_w;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_b_found    = 1'b0;
    w_b_idx      = '0;
    w_b_best     = '0;
    for (int i = 0; i < MaxWrTxns; i++) begin
      if (r_state[i] != S_FREE) w_cnt_n[i] = sat_inc(r_cnt[i], w_tick);
      if (!w_free_found && r_state[i] == S_FREE) begin
        w_free_found = 1'b1;
        w_free_idx   = SW'(i);
      end
      // Strict '>' keeps the lowest index on equal counters.
      if (r_state[i] == S_BWAIT && r_id[i] == b_id_i && (!w_b_found || r_cnt[i] > w_b_best)) begin
        w_b_found = 1'b1;
        w_b_idx   = SW'(i);
        w_b_best  = r_cnt[i];
      end
    end

    w_alloc   = w_aw_hs && !r_full && w_free_found;
    w_bypass  = w_w_hs && w_fifo_empty && w_alloc;
    w_unexp_w = w_w_hs && w_fifo_empty && !w_aw_hs;
    w_pop     = w_w_hs && !w_fifo_empty && w_last_i;
    // A bypassed burst that has not finished must still be found at the FIFO head.
    w_push    = w_alloc && !(w_bypass && w_last_i);
    w_b_free  = w_b_hs && w_b_found;
    w_unexp_b = w_b_hs && !w_b_found;

    if (w_w_hs && !w_fifo_empty) begin
      if (w_last_i) begin
        w_state_n[w_head] = S_BWAIT;
        w_lat_w_n[w_head] = sat_inc(r_cnt[w_head], w_tick);
        w_cnt_n[w_head]   = '0;
      end else if (r_state[w_head] == S_WWAIT) begin
        w_state_n[w_head] = S_WDATA;
      end
    end

    if (w_alloc) begin
      w_id_n[w_free_idx]     = aw_id_i;
      w_len_n[w_free_idx]    = aw_len_i;
      w_lat_aw_n[w_free_idx] = r_aw_cnt;
      w_lat_w_n[w_free_idx]  = '0;
      w_cnt_n[w_free_idx]    = '0;
      if (!w_bypass)     w_state_n[w_free_idx] = S_WWAIT;
      else if (w_last_i) w_state_n[w_free_idx] = S_BWAIT;
      else               w_state_n[w_free_idx] = S_WDATA;
    end

    if (w_b_free) w_state_n[w_b_idx] = S_FREE;

    w_outst_n = '0;
    for (int i = 0; i < MaxWrTxns; i++)
      if (w_state_n[i] != S_FREE) w_outst_n = w_outst_n + 1'b1;

    if (w_aw_hs || !aw_valid_i) w_aw_cnt_n = '0;
    else                        w_aw_cnt_n = sat_inc(r_aw_cnt, w_tick);

    w_to_hit   = 1'b0;
    w_to_phase = 2'd0;
    w_to_id    = '0;
    if (aw_valid_i && r_aw_cnt > budget_aw_i) begin
      w_to_hit = 1'b1;
      w_to_id  = aw_id_i;
    end
    for (int i = 0; i < MaxWrTxns; i++) begin
      if (!w_to_hit) begin
        if ((r_state[i] == S_WWAIT || r_state[i] == S_WDATA) &&
            {1'b0, r_cnt[i]} > w_budget(r_len[i], budget_w_i)) begin
          w_to_hit   = 1'b1;
          w_to_phase = 2'd1;
          w_to_id    = r_id[i];
        end else if (r_state[i] == S_BWAIT && r_cnt[i] > budget_b_i) begin
          w_to_hit   = 1'b1;
          w_to_phase = 2'd2;
          w_to_id    = r_id[i];
        end
      end
    end
  end

  // State register and control/status flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni || clr_i) begin
      // clr_i shares the reset values; handled synchronously here.
      for (int i = 0; i < MaxWrTxns; i++) begin
        r_state[i] <= S_FREE;
        r_cnt[i]   <= '0;
      end
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_fifo_cnt  <= '0;
      r_aw_cnt    <= '0;
      r_presc     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_outst     <= '0;
      r_timeout   <= 1'b0;
      r_to_phase  <= 2'd0;
      r_to_id     <= '0;
      r_overflow  <= 1'b0;
      r_unexp_w   <= 1'b0;
      r_unexp_b   <= 1'b0;
      r_lat_valid <= 1'b0;
      r_lat_id    <= '0;
      r_lat_aw_o  <= '0;
      r_lat_w_o   <= '0;
      r_lat_b_o   <= '0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_aw_cnt   <= w_aw_cnt_n;
      r_presc    <= (PrescalerDiv > 1) ? r_presc + 1'b1 : '0;
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_fifo_cnt <= r_fifo_cnt + OW'(w_push) - OW'(w_pop);
      r_outst    <= w_outst_n;
      r_full     <= (w_outst_n == OW'(MaxWrTxns));
      r_empty    <= (w_outst_n == '0);
      if (!r_timeout && w_to_hit) begin
        r_timeout  <= 1'b1;
        r_to_phase <= w_to_phase;
        r_to_id    <= w_to_id;
      end
      if (w_aw_hs && r_full) r_overflow <= 1'b1;
      r_unexp_w   <= w_unexp_w;
      r_unexp_b   <= w_unexp_b;
      r_lat_valid <= w_b_free;
      if (w_b_free) begin
        r_lat_id   <= r_id[w_b_idx];
        r_lat_aw_o <= r_lat_aw[w_b_idx];
        r_lat_w_o  <= r_lat_w[w_b_idx];
        r_lat_b_o  <= sat_inc(r_cnt[w_b_idx], w_tick);
      end
    end
  end

  // Payload storage; only meaningful while the owning slot is occupied.
  always_ff @(posedge clk_i) begin
    r_id     <= w_id_n;
    r_len    <= w_len_n;
    r_lat_aw <= w_lat_aw_n;
    r_lat_w  <= w_lat_w_n;
    if (w_push) r_fifo[r_wr_ptr] <= w_free_idx;
  end

  always_comb begin
    full_o          = r_full;
    empty_o         = r_empty;
    outstanding_o   = r_outst;
    timeout_o       = r_timeout;
    timeout_phase_o = r_to_phase;
    timeout_id_o    = r_to_id;
    overflow_o      = r_overflow;
    unexpected_w_o  = r_unexp_w;
    unexpected_b_o  = r_unexp_b;
    lat_valid_o     = r_lat_valid;
    lat_id_o        = r_lat_id;
    lat_aw_o        = r_lat_aw_o;
    lat_w_o         = r_lat_w_o;
    lat_b_o         = r_lat_b_o;
  end

endmodule
